// File: rtl/huff_block_ctrl.sv
// huff_block_ctrl: collects a block of 4-bit symbols into a histogram, then sequences tree build and encode under a watchdog.
module huff_block_ctrl #(
  parameter int BLOCK_LEN = 255,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [3:0]       data_in_i,
  input  logic             flush_i,
  output logic             wr_ready_o,
  output logic             drop_o,
  input  logic [3:0]       freq_addr_i,
  output logic [CNT_W-1:0] freq_data_o,
  output logic [CNT_W-1:0] sym_count_o,
  output logic             build_start_o,
  input  logic             build_done_i,
  output logic             enc_start_o,
  input  logic             enc_done_i,
  output logic             busy_o,
  output logic             block_done_o,
  output logic             err_timeout_o
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, COLLECT, BUILD, ENCODE, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] freq_q [16];
  logic [CNT_W-1:0] cnt_q;
  logic [WD_W-1:0] wd_q;
  logic wr_ready_q, drop_q, build_start_q, enc_start_q, busy_q, block_done_q, err_q;
  logic open_w, acc, expire, clr;
  always_comb begin
    open_w = state_q == IDLE || state_q == COLLECT;
    acc    = wr_en_i && open_w;
    expire = wd_q == WD_W'(TIMEOUT - 1) &&
             ((state_q == BUILD && !build_done_i) || (state_q == ENCODE && !enc_done_i));
    clr    = state_q == DONE || expire;
    state_d = state_q;
    // flush alone in IDLE is ignored so no empty block is ever built
    if (open_w && ((acc && cnt_q == CNT_W'(BLOCK_LEN - 1)) || (flush_i && (acc || state_q == COLLECT))))
      state_d = BUILD;
    else if (acc)
      state_d = COLLECT;
    else if (state_q == BUILD && build_done_i)
      state_d = ENCODE;
    else if (state_q == ENCODE && enc_done_i)
      state_d = DONE;
    else if (clr)
      state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wd_q          <= '0;
      wr_ready_q    <= 1'b1;
      drop_q        <= 1'b0;
      build_start_q <= 1'b0;
      enc_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      block_done_q  <= 1'b0;
      err_q         <= 1'b0;
      for (int i = 0; i < 16; i++) freq_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      wd_q          <= state_d != state_q ? '0 : wd_q + WD_W'(1);
      wr_ready_q    <= state_d == IDLE || state_d == COLLECT;
      drop_q        <= wr_en_i && !open_w;
      build_start_q <= state_d == BUILD && state_q != BUILD;
      enc_start_q   <= state_d == ENCODE && state_q != ENCODE;
      busy_q        <= state_d != IDLE;
      block_done_q  <= state_d == DONE;
      err_q         <= err_q || expire;
      cnt_q         <= clr ? '0 : cnt_q + CNT_W'(acc);
      for (int i = 0; i < 16; i++)
        freq_q[i] <= clr ? '0 : freq_q[i] + CNT_W'(acc && data_in_i == 4'(i));
    end
  end
  assign freq_data_o   = freq_q[freq_addr_i];
  assign sym_count_o   = cnt_q;
  assign wr_ready_o    = wr_ready_q;
  assign drop_o        = drop_q;
  assign build_start_o = build_start_q;
  assign enc_start_o   = enc_start_q;
  assign busy_o        = busy_q;
  assign block_done_o  = block_done_q;
  assign err_timeout_o = err_q;
endmodule

// File: tb/tb_huff_block_ctrl.sv
// tb_huff_block_ctrl: directed stimulus with a queued scoreboard drained by a negedge monitor.
module tb_huff_block_ctrl;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic wr_en, flush, bdone, edone, wr_ready, drop, build_start, enc_start, busy, block_done, err;
  logic [3:0] din, addr;
  logic [7:0] freq, sym;
  logic w_wr, w_flush, w_ready, w_drop, w_bs, w_es, w_busy, w_bd, w_err;
  logic [3:0] w_din, w_addr;
  logic [7:0] w_freq, w_sym;
  huff_block_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .data_in_i(din), .flush_i(flush),
    .wr_ready_o(wr_ready), .drop_o(drop), .freq_addr_i(addr), .freq_data_o(freq),
    .sym_count_o(sym), .build_start_o(build_start), .build_done_i(bdone),
    .enc_start_o(enc_start), .enc_done_i(edone), .busy_o(busy),
    .block_done_o(block_done), .err_timeout_o(err)
  );
  huff_block_ctrl #(.TIMEOUT(16)) u_wd (
    .clk_i(clk), .rst_i(rst), .wr_en_i(w_wr), .data_in_i(w_din), .flush_i(w_flush),
    .wr_ready_o(w_ready), .drop_o(w_drop), .freq_addr_i(w_addr), .freq_data_o(w_freq),
    .sym_count_o(w_sym), .build_start_o(w_bs), .build_done_i(1'b0),
    .enc_start_o(w_es), .enc_done_i(1'b0), .busy_o(w_busy),
    .block_done_o(w_bd), .err_timeout_o(w_err)
  );
  localparam int S_SYM = 0, S_FREQ = 1, S_RDY = 2, S_BUSY = 3, S_ERR = 4, S_BS = 5, S_ES = 6,
                 S_BD = 7, S_NBS = 8, S_NES = 9, S_NBD = 10, S_NDROP = 11, S_DROP = 12,
                 W_BUSY = 13, W_ERR = 14, W_SYM = 15, W_FREQ = 16, W_RDY = 17, W_NBD = 18;
  typedef struct {string name; int sig; int exp;} chk_t;
  chk_t sb[$];
  chk_t c;
  int errors = 0, checks = 0;
  int n_bs = 0, n_es = 0, n_bd = 0, n_drop = 0, n_wbd = 0;
  int hist[16] = '{0, 20, 30, 20, 30, 20, 30, 50, 10, 45, 0, 0, 0, 0, 0, 0};
  function automatic int val(input int s);
    case (s)
      S_SYM:   return int'(sym);
      S_FREQ:  return int'(freq);
      S_RDY:   return int'(wr_ready);
      S_BUSY:  return int'(busy);
      S_ERR:   return int'(err);
      S_BS:    return int'(build_start);
      S_ES:    return int'(enc_start);
      S_BD:    return int'(block_done);
      S_NBS:   return n_bs;
      S_NES:   return n_es;
      S_NBD:   return n_bd;
      S_NDROP: return n_drop;
      S_DROP:  return int'(drop);
      W_BUSY:  return int'(w_busy);
      W_ERR:   return int'(w_err);
      W_SYM:   return int'(w_sym);
      W_FREQ:  return int'(w_freq);
      W_RDY:   return int'(w_ready);
      W_NBD:   return n_wbd;
      default: return -1;
    endcase
  endfunction
  always @(negedge clk) begin
    if (build_start) n_bs++;
    if (enc_start) n_es++;
    if (block_done) n_bd++;
    if (drop) n_drop++;
    if (w_bd) n_wbd++;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      checks++;
      if (val(c.sig) != c.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d at %0t", c.name, val(c.sig), c.exp, $time);
      end
    end
  end
  task automatic chk(input string n, input int s, input int e);
    sb.push_back('{n, s, e});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1;
      din = s;
      tick();
    end
    wr_en = 0;
  endtask
  task automatic rd(input int a, input int e, input string n);
    addr = 4'(a);
    chk(n, S_FREQ, e);
    tick();
  endtask
  initial begin
    {wr_en, flush, bdone, edone, w_wr, w_flush} = '0;
    din = 0; addr = 0; w_din = 0; w_addr = 0;
    tick();
    chk("rst_ready", S_RDY, 1); chk("rst_busy", S_BUSY, 0); chk("rst_sym", S_SYM, 0);
    chk("rst_err", S_ERR, 0); chk("rst_bs", S_BS, 0); chk("rst_drop", S_DROP, 0);
    tick();
    rst = 0;
    tick();
    for (int s = 1; s <= 9; s++) wr(4'(s), hist[s]);
    chk("full_sym", S_SYM, 255); chk("full_bs", S_BS, 1); chk("full_nbs", S_NBS, 1);
    chk("full_busy", S_BUSY, 1); chk("full_rdy", S_RDY, 0);
    for (int a = 0; a < 16; a++) rd(a, hist[a], "hist");
    wr_en = 1; din = 0;
    repeat (4) tick();
    wr_en = 0;
    tick();
    chk("ndrop", S_NDROP, 4); chk("drop_end", S_DROP, 0); chk("drop_sym", S_SYM, 255);
    rd(0, 0, "drop_f0");
    rd(7, 50, "drop_f7");
    bdone = 1;
    tick();
    bdone = 0;
    chk("es", S_ES, 1); chk("nes", S_NES, 1); chk("nbs_once", S_NBS, 1);
    repeat (9) tick();
    edone = 1;
    tick();
    edone = 0;
    chk("bd", S_BD, 1); chk("nbd", S_NBD, 1); chk("bd_rdy", S_RDY, 0); chk("nes_once", S_NES, 1);
    tick();
    chk("post_rdy", S_RDY, 1); chk("post_busy", S_BUSY, 0); chk("post_sym", S_SYM, 0);
    chk("post_nbd", S_NBD, 1);
    for (int a = 0; a < 16; a++) rd(a, 0, "post_hist");
    flush = 1; bdone = 1; edone = 1;
    tick();
    flush = 0; bdone = 0; edone = 0;
    chk("idle_flush_busy", S_BUSY, 0); chk("idle_nbs", S_NBS, 1); chk("idle_nbd", S_NBD, 1);
    tick();
    wr(3, 5);
    chk("c5_sym", S_SYM, 5); chk("c5_rdy", S_RDY, 1);
    wr_en = 1; flush = 1; din = 3;
    tick();
    wr_en = 0; flush = 0;
    chk("fl_sym", S_SYM, 6); chk("fl_bs", S_BS, 1); chk("fl_nbs", S_NBS, 2);
    addr = 3; chk("fl_f3", S_FREQ, 6);
    bdone = 1;
    tick();
    bdone = 0;
    chk("fl_es", S_ES, 1); chk("fl_nes", S_NES, 2);
    repeat (2) tick();
    edone = 1;
    tick();
    edone = 0;
    chk("fl_bd", S_BD, 1); chk("fl_nbd", S_NBD, 2);
    tick();
    chk("fl_clr", S_SYM, 0);
    wr(5, 100);
    chk("mid_sym", S_SYM, 100); addr = 5; chk("mid_f5", S_FREQ, 100);
    tick();
    rst = 1;
    chk("ar_sym", S_SYM, 0); chk("ar_busy", S_BUSY, 0); chk("ar_rdy", S_RDY, 1);
    chk("ar_f5", S_FREQ, 0);
    tick();
    rst = 0;
    wr(2, 3);
    chk("re_sym", S_SYM, 3); addr = 2; chk("re_f2", S_FREQ, 3); chk("re_err", S_ERR, 0);
    tick();
    w_wr = 1; w_flush = 1; w_din = 4; w_addr = 4;
    tick();
    w_wr = 0; w_flush = 0;
    chk("wd_busy", W_BUSY, 1); chk("wd_f4", W_FREQ, 1); chk("wd_sym", W_SYM, 1);
    repeat (15) tick();
    chk("wd_pre_busy", W_BUSY, 1); chk("wd_pre_err", W_ERR, 0);
    tick();
    chk("wd_err", W_ERR, 1); chk("wd_idle", W_BUSY, 0); chk("wd_clr_sym", W_SYM, 0);
    chk("wd_clr_f4", W_FREQ, 0); chk("wd_rdy", W_RDY, 1); chk("wd_nbd", W_NBD, 0);
    repeat (3) tick();
    chk("wd_sticky", W_ERR, 1);
    tick();
    tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
